// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg: shared FIFO widths, read-FSM state type and Gray-code helpers.
// Revision: 1.0
// ============================================================================
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int PTR_MAX_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_t;

  // Operate on zero-extended pointers, so one pair serves every pointer
  // width up to PTR_MAX_W; callers cast back down to their own width.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_2ff.sv
`default_nettype none
// ============================================================================
// fifo_sync_2ff: STAGES-deep flop chain for crossing a Gray pointer between
// clock domains; asynchronous active-high reset to zero.
// Revision: 1.0
// ============================================================================
module fifo_sync_2ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl: read-domain controller of the async FIFO; syncs the write
// pointer, tracks empty/level, fetches RAM words onto a valid/ready port.
// Revision: 1.0
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      w_wq_gray;
  logic [PTR_W-1:0]      w_wq_bin;
  logic [PTR_W-1:0]      w_bin_inc;
  logic [PTR_W-1:0]      w_gray_inc;
  logic [PTR_W-1:0]      r_bin;
  logic [PTR_W-1:0]      r_rptr_gray;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic                  w_rd_inc;
  logic                  w_capture;

  fifo_sync_2ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (r_clk),
    .rst (r_rst),
    .i_d (wptr_gray),
    .o_q (w_wq_gray)
  );

  assign w_wq_bin   = PTR_W'(gray2bin(PTR_MAX_W'(w_wq_gray)));
  assign w_bin_inc  = r_bin + PTR_W'(1);
  assign w_gray_inc = PTR_W'(bin2gray(PTR_MAX_W'(w_bin_inc)));

  assign rempty     = (r_rptr_gray == w_wq_gray);
  assign rlevel     = w_wq_bin - r_bin;
  assign ram_raddr  = r_bin[ADDR_WIDTH-1:0];
  assign rptr_gray  = r_rptr_gray;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_inc    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rempty) begin
          w_rd_inc    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        // RAM output now holds the word addressed before the increment.
        w_capture   = 1'b1;
        w_state_nxt = VALID;
      end
      VALID: begin
        if (dout_ready) begin
          if (!rempty) begin
            w_rd_inc    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_rptr_gray  <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout_valid <= (w_state_nxt == VALID);
      if (w_rd_inc) begin
        r_bin       <= w_bin_inc;
        r_rptr_gray <= w_gray_inc;
      end
    end
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_dout <= '0;
    end else if (w_capture) begin
      r_dout <= ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_ctrl: scoreboard bench for fifo_rd_ctrl with a registered-read
// RAM model and a write-pointer driver. Revision: 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [4:0] wptr_gray = '0;
  logic [4:0] rptr_gray;
  logic [3:0] ram_raddr;
  logic [7:0] ram_rdata = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       rempty;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  int         rx_cyc [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [4:0] wbin = '0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_dout = '0;
  logic [4:0] prev_rg = '0;
  logic       saw_wrap = 1'b0;

  fifo_rd_ctrl #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rempty     (rempty),
    .rlevel     (rlevel)
  );

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) begin
    ram_rdata <= mem[ram_raddr];
    cyc       <= cyc + 1;
  end

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic push_bulk(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wbin[3:0]] = 8'(base + 8'(i));
      q.push_back(8'(base + 8'(i)));
      wbin = wbin + 5'd1;
    end
    wptr_gray = to_gray(wbin);
  endtask

  task automatic do_reset();
    r_rst      = 1'b1;
    dout_ready = 1'b0;
    wbin       = '0;
    wptr_gray  = '0;
    step(2);
    q.delete();
    rx_cyc.delete();
    saw_wrap = 1'b0;
    r_rst    = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && !dout_valid) break;
      step(1);
    end
    chk(tag, q.size(), 0);
  endtask

  // Scoreboard side: every accepted word must be the oldest one written.
  always @(negedge r_clk) begin
    if (r_rst) begin
      prev_hold = 1'b0;
      prev_rg   = rptr_gray;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout, prev_dout);
      end
      if (rptr_gray != prev_rg) begin
        chk("gray_step", $countones(rptr_gray ^ prev_rg), 1);
        if (prev_rg == 5'b10000 && rptr_gray == 5'b00000) saw_wrap = 1'b1;
      end
      prev_rg = rptr_gray;
      if (dout_valid && dout_ready) begin
        chk("word_expected", q.size() > 0, 1);
        if (q.size() > 0) chk("data", dout, q.pop_front());
        rx_cyc.push_back(cyc);
      end
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_e;
    int n_valid;
    int sent;

    // Reset with a non-zero write pointer already present.
    r_rst = 1'b1;
    push_bulk(4, 8'h10);
    step(2);
    chk("rst_rempty", rempty, 1);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_rptr", rptr_gray, 0);
    r_rst = 1'b0;
    step(1);
    chk("sync_1edge_empty", rempty, 1);
    step(1);
    chk("sync_2edge_empty", rempty, 0);
    chk("sync_2edge_level", rlevel, 4);
    dout_ready = 1'b1;
    wait_drain("rst_drain", 60);

    // Single word: latency and one-cycle valid pulse.
    do_reset();
    dout_ready = 1'b1;
    push_bulk(1, 8'hA5);
    first_e = 0;
    n_valid = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (dout_valid) begin
        n_valid++;
        if (first_e == 0) first_e = e;
      end
    end
    chk("single_latency", first_e, 4);
    chk("single_valid_cycles", n_valid, 1);
    chk("single_rptr", rptr_gray, 5'b00001);
    chk("single_rempty", rempty, 1);
    chk("single_rx", rx_cyc.size(), 1);

    // Backpressure: first word held, then one word per two cycles.
    do_reset();
    push_bulk(3, 8'h11);
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    q.delete();
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    step(10);
    chk("bp_dout", dout, 8'h11);
    chk("bp_valid", dout_valid, 1);
    chk("bp_raddr", ram_raddr, 1);
    chk("bp_rptr", rptr_gray, 5'b00001);
    chk("bp_level", rlevel, 2);
    chk("bp_no_rx", rx_cyc.size(), 0);
    dout_ready = 1'b1;
    wait_drain("bp_drain", 40);
    chk("bp_rx", rx_cyc.size(), 3);
    if (rx_cyc.size() == 3) begin
      chk("bp_tput_a", rx_cyc[1] - rx_cyc[0], 2);
      chk("bp_tput_b", rx_cyc[2] - rx_cyc[1], 2);
    end

    // Full FIFO: level 16, then drain in address order.
    do_reset();
    push_bulk(16, 8'h80);
    step(2);
    chk("full_level", rlevel, 16);
    chk("full_rempty", rempty, 0);
    chk("full_raddr", ram_raddr, 0);
    step(1);
    chk("full_first_fetch", ram_raddr, 1);
    chk("full_level_after", rlevel, 15);
    dout_ready = 1'b1;
    wait_drain("full_drain", 100);
    chk("full_end_rempty", rempty, 1);
    chk("full_end_level", rlevel, 0);
    chk("full_end_rptr", rptr_gray, 5'b11000);
    chk("full_rx", rx_cyc.size(), 16);

    // Stream of 40 words with random backpressure across the pointer wrap.
    do_reset();
    sent = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sent == 40 && q.size() == 0 && !dout_valid) break;
      dout_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40 && q.size() < 15 && $urandom_range(0, 1) == 1) begin
        push_bulk(1, 8'(sent * 7 + 3));
        sent++;
      end
      step(1);
    end
    chk("wrap_drain", q.size(), 0);
    chk("wrap_sent", sent, 40);
    chk("wrap_rx", rx_cyc.size(), 40);
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_rptr", rptr_gray, 5'b01100);

    // Reset while a fetch is in flight: the word is discarded.
    do_reset();
    dout_ready = 1'b1;
    push_bulk(1, 8'h5A);
    step(3);
    chk("mid_fetch_raddr", ram_raddr, 1);
    chk("mid_fetch_valid", dout_valid, 0);
    r_rst = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_raddr", ram_raddr, 0);
    chk("mid_rst_rptr", rptr_gray, 0);
    chk("mid_rst_rempty", rempty, 1);
    q.delete();
    wbin      = '0;
    wptr_gray = '0;
    step(1);
    r_rst = 1'b0;
    step(6);
    chk("mid_after_valid", dout_valid, 0);
    chk("mid_after_rempty", rempty, 1);
    chk("mid_after_rx", rx_cyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller of the asynchronous FIFO, the counterpart of the write-domain logic that fills the dual-port RAM. It runs entirely in the read clock domain. It synchronizes the write pointer, keeps the read pointer in binary and Gray form, derives empty and fill level, and issues RAM reads. Fetched words are presented on a registered valid/ready output port.

## Interface
- DATA_WIDTH, 8, width of a FIFO word
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- SYNC_STAGES, 2, flops in the write-pointer synchronizer (legal value ≥ 2)

- r_clk  in  1  read clock; all state on rising edge
- r_rst  in  1  asynchronous, active-high reset
- wptr_gray  in  ADDR_WIDTH+1  write pointer, Gray coded, from the write clock domain
- rptr_gray  out  ADDR_WIDTH+1  registered read pointer, Gray coded, to the write-side synchronizer
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_rdata  in  DATA_WIDTH  RAM read data; registered read, valid one r_clk after ram_raddr is presented
- dout  out  DATA_WIDTH  output word (registered)
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout
- rempty  out  1  FIFO empty, as seen in the read domain
- rlevel  out  ADDR_WIDTH+1  occupancy estimate, 0..2^ADDR_WIDTH

## Operation
- wq_gray is wptr_gray passed through SYNC_STAGES flops. wq_bin = gray2bin(wq_gray).
- rbin is the binary read pointer. rptr_gray = bin2gray(rbin), registered alongside rbin.
- ram_raddr = rbin[ADDR_WIDTH-1:0]. It is combinational from the rbin register.
- rempty = (rptr_gray == wq_gray). This is combinational from registers.
- rlevel = wq_bin - rbin, taken modulo 2^(ADDR_WIDTH+1). Pointer wrap is handled by this modulo arithmetic.
- FSM states and transitions:
  - IDLE: dout_valid=0. If !rempty, rbin increments and the next state is FETCH. Otherwise stay in IDLE.
  - FETCH: ram_rdata now holds the word at the previous address. It is captured into dout, and the next state is VALID.
  - VALID: dout_valid=1.
    - If dout_ready and !rempty: rbin increments and the next state is FETCH.
    - If dout_ready and rempty: the next state is IDLE.
    - If !dout_ready: hold dout, hold rbin, stay in VALID.
- rbin advances only on the IDLE→FETCH and VALID→FETCH transitions. A read is never issued while rempty=1, so there is no underflow.
- dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
- Simultaneous write-pointer movement and a read in the same cycle: rempty and rlevel use the values registered at that edge. A new word becomes visible SYNC_STAGES cycles after wptr_gray changes.

## Timing
- Reset values: rbin=0, rptr_gray=0, synchronizer flops=0, state=IDLE, dout=0, dout_valid=0. As a result rempty=1, rlevel=0, ram_raddr=0.
- r_rst asserted mid-operation: everything clears immediately. A word in dout or an in-flight fetch is discarded.
- Latency, with FIFO non-empty and the block in IDLE: edge 0 rbin increments, edge 1 dout captured, dout_valid high after edge 1.
- Sustained throughput: one word per 2 r_clk cycles.
- Write to read visibility: a wptr_gray change reaches rempty/rlevel after SYNC_STAGES edges, plus one more edge to start a fetch.
- rptr_gray changes on the same edge as rbin. It changes by exactly one bit per increment, including the wrap from 2^(ADDR_WIDTH+1)-1 to 0.

## Structure
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parameterized on pointer width.
  - FSM state enum (IDLE, FETCH, VALID).
  - Default DATA_WIDTH and ADDR_WIDTH constants, also used by the write-side controller and the RAM.
- Sub-module fifo_sync_2ff: a generic SYNC_STAGES-deep flop chain with width parameter and asynchronous active-high reset to 0. The write-side controller reuses it for rptr_gray.

## Test plan
- Reset: hold r_rst with wptr_gray=5'b00110 → rempty=1, rlevel=0, dout_valid=0, ram_raddr=0, rptr_gray=0. After release, rempty=0 after 2 edges and rlevel=4.
- Single word: RAM[0]=8'hA5, wptr_gray 0→1, dout_ready=1 → dout=8'hA5 with dout_valid=1 for exactly one cycle, then IDLE; rptr_gray=1, rempty=1.
- Backpressure: 3 words (11,22,33) present, dout_ready=0 for 10 cycles → dout holds 8'h11 with dout_valid high and rbin=1. Release → 8'h22 then 8'h33, one word per 2 cycles.
- Fill to full: wptr bin=16 (gray 5'b11000), rbin=0 → rlevel=16. Drain all 16 words in address order 0..15; rempty asserts after the last fetch.
- Wrap: preload rbin near 31 via a 40-word stream → rptr_gray goes 5'b10000→5'b00000 on the wrap with a single-bit change; data order preserved.
- Reset mid-stream: assert r_rst in state FETCH → dout_valid=0 immediately, rbin=0, next cycle state=IDLE.
